// File: rtl/bus_cycle_terminator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bus_cycle_terminator                                           |
// | Purpose : Responder-side termination of every 68030 bus cycle. Takes    |
// |           the function/device decode and port width sampled at the      |
// |           start of a cycle, then inserts wait states and drives DSACK,   |
// |           AVEC or BERR. It leaves FPU cycles to the FPU.                 |
// | Ports   : clock, reset         - clock, async active-high reset          |
// |           as                   - synchronised address strobe (high)     |
// |           function_selected    - one-hot function decode                |
// |           device_selected      - one-hot device decode (0 = unmapped)   |
// |           port_width           - port width of the selected device      |
// |           ext_ack              - ack from externally terminated devices |
// |           dsack_n[1:0]         - DSACK1/DSACK0, active-low              |
// |           berr_n, avec_n       - bus error / autovector, active-low     |
// |           cycle_active         - high while a cycle is in progress      |
// | Options : BUS_TIMEOUT_EN - when defined, an external cycle that is not   |
// |           acknowledged within TIMEOUT_CYCLES clocks ends in BERR.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+

// Decode encodings shared with the address decoder. They are guarded so
// that a project-wide definition file may supply them first.
`ifndef FUNCTION_SELECTED_MAXPOS
`define FUNCTION_SELECTED_MAXPOS 2
`endif
`ifndef FUNCTION_NORMAL
`define FUNCTION_NORMAL 0
`endif
`ifndef FUNCTION_INT_ACK
`define FUNCTION_INT_ACK 1
`endif
`ifndef FUNCTION_FPU
`define FUNCTION_FPU 2
`endif
`ifndef DEVICE_SELECTED_MAXPOS
`define DEVICE_SELECTED_MAXPOS 12
`endif
`ifndef DEVICE_NULL
`define DEVICE_NULL '0
`endif
`ifndef DEVICE_ROM
`define DEVICE_ROM 0
`endif
`ifndef DEVICE_REGISTER8
`define DEVICE_REGISTER8 1
`endif
`ifndef DEVICE_REGISTER16
`define DEVICE_REGISTER16 2
`endif
`ifndef DEVICE_REGISTER32
`define DEVICE_REGISTER32 3
`endif
`ifndef DEVICE_QUART
`define DEVICE_QUART 4
`endif
`ifndef DEVICE_SIMM
`define DEVICE_SIMM 5
`endif
`ifndef DEVICE_SLOT0
`define DEVICE_SLOT0 6
`endif
`ifndef DEVICE_SLOT1
`define DEVICE_SLOT1 7
`endif
`ifndef DEVICE_SLOT2
`define DEVICE_SLOT2 8
`endif
`ifndef DEVICE_SLOT3
`define DEVICE_SLOT3 9
`endif
`ifndef DEVICE_IDE1
`define DEVICE_IDE1 10
`endif
`ifndef DEVICE_IDE3
`define DEVICE_IDE3 11
`endif
`ifndef DEVICE_ETH
`define DEVICE_ETH 12
`endif
`ifndef PORT_WIDTH_WIDTH
`define PORT_WIDTH_WIDTH 2
`endif
`ifndef PORT_WIDTH_NULL
`define PORT_WIDTH_NULL 2'b00
`endif
`ifndef PORT_WIDTH_BYTE
`define PORT_WIDTH_BYTE 2'b01
`endif
`ifndef PORT_WIDTH_WORD
`define PORT_WIDTH_WORD 2'b10
`endif
`ifndef PORT_WIDTH_LONG
`define PORT_WIDTH_LONG 2'b11
`endif

module bus_cycle_terminator #(
    parameter int ROM_WAIT       = 2,
    parameter int REG_WAIT       = 0,
    parameter int SIMM_WAIT      = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 as,
    input  logic [`FUNCTION_SELECTED_MAXPOS:0]   function_selected,
    input  logic [`DEVICE_SELECTED_MAXPOS:0]     device_selected,
    input  logic [`PORT_WIDTH_WIDTH-1:0]         port_width,
    input  logic                                 ext_ack,
    output logic [1:0]                           dsack_n,
    output logic                                 berr_n,
    output logic                                 avec_n,
    output logic                                 cycle_active
);

    // The 8-bit counter cannot represent values outside these ranges.
    if (ROM_WAIT < 0 || ROM_WAIT > 255 || REG_WAIT < 0 || REG_WAIT > 255 ||
        SIMM_WAIT < 0 || SIMM_WAIT > 255 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_range_error
        $error("bus_cycle_terminator: parameter out of range");
    end

    localparam logic [7:0] C_ROM_WAIT  = 8'(ROM_WAIT);
    localparam logic [7:0] C_REG_WAIT  = 8'(REG_WAIT);
    localparam logic [7:0] C_SIMM_WAIT = 8'(SIMM_WAIT);
`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_WAIT_EXT = 3'd2,
        ST_ACK      = 3'd3,
        ST_AVEC     = 3'd4,
        ST_BERR     = 3'd5,
        ST_PASS     = 3'd6
    } state_t;

    state_t                         state_q, state_d;
    logic [7:0]                     count_q, count_d;
    logic [`PORT_WIDTH_WIDTH-1:0]   width_q, width_d;
    logic [1:0]                     dsack_q, dsack_d;
    logic                           berr_q, berr_d;
    logic                           avec_q, avec_d;
    logic                           active_q, active_d;

    logic                           is_ext_dev;
    logic [7:0]                     wait_sel;

    assign is_ext_dev = device_selected[`DEVICE_SLOT0] | device_selected[`DEVICE_SLOT1] |
                        device_selected[`DEVICE_SLOT2] | device_selected[`DEVICE_SLOT3] |
                        device_selected[`DEVICE_IDE1]  | device_selected[`DEVICE_IDE3]  |
                        device_selected[`DEVICE_ETH];

    always_comb begin
        wait_sel = C_REG_WAIT;
        if (device_selected[`DEVICE_ROM]) begin
            wait_sel = C_ROM_WAIT;
        end else if (device_selected[`DEVICE_SIMM]) begin
            wait_sel = C_SIMM_WAIT;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        width_d = width_q;

        case (state_q)
            ST_IDLE: begin
                if (as) begin
                    // Width is captured here so decode changes mid-cycle
                    // cannot alter the DSACK encoding.
                    width_d = port_width;
                    if (function_selected[`FUNCTION_INT_ACK]) begin
                        state_d = ST_AVEC;
                    end else if (function_selected[`FUNCTION_FPU]) begin
                        state_d = ST_PASS;
                    end else if (!function_selected[`FUNCTION_NORMAL] ||
                                 device_selected == `DEVICE_NULL ||
                                 port_width == `PORT_WIDTH_NULL) begin
                        state_d = ST_BERR;
                    end else if (is_ext_dev) begin
                        state_d = ST_WAIT_EXT;
                        count_d = 8'd0;
                    end else begin
                        state_d = ST_WAIT;
                        count_d = wait_sel;
                    end
                end
            end
            ST_WAIT: begin
                if (!as) begin
                    state_d = ST_IDLE;
                end else if (count_q == 8'd0) begin
                    state_d = ST_ACK;
                end else begin
                    count_d = count_q - 8'd1;
                end
            end
            ST_WAIT_EXT: begin
                if (!as) begin
                    state_d = ST_IDLE;
                end else if (ext_ack) begin
                    state_d = ST_ACK;
`ifdef BUS_TIMEOUT_EN
                end else if (count_q == C_TIMEOUT_LAST) begin
                    state_d = ST_BERR;
                end else begin
                    count_d = count_q + 8'd1;
`endif
                end
            end
            default: begin
                // ACK, AVEC, BERR and PASS hold until the strobe drops.
                if (!as) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so they change on the same edge as the state.
    always_comb begin
        dsack_d  = 2'b11;
        berr_d   = 1'b1;
        avec_d   = 1'b1;
        active_d = (state_d != ST_IDLE);
        case (state_d)
            ST_ACK: begin
                case (width_d)
                    `PORT_WIDTH_LONG: dsack_d = 2'b00;
                    `PORT_WIDTH_WORD: dsack_d = 2'b01;
                    `PORT_WIDTH_BYTE: dsack_d = 2'b10;
                    default:          dsack_d = 2'b11;
                endcase
            end
            ST_AVEC: avec_d = 1'b0;
            ST_BERR: berr_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= 8'd0;
            width_q  <= `PORT_WIDTH_NULL;
            dsack_q  <= 2'b11;
            berr_q   <= 1'b1;
            avec_q   <= 1'b1;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            width_q  <= width_d;
            dsack_q  <= dsack_d;
            berr_q   <= berr_d;
            avec_q   <= avec_d;
            active_q <= active_d;
        end
    end

    assign dsack_n      = dsack_q;
    assign berr_n       = berr_q;
    assign avec_n       = avec_q;
    assign cycle_active = active_q;

endmodule

`default_nettype wire
